push_button_conditioner: RTL

- Conditions the raw board push buttons before they reach the PWM/LED controller and the 7-segment display logic.
- Per button, it synchronises the pin, debounces it, and produces clean level and single-cycle event outputs.
- Events are press, release, long-press, and auto-repeat while held.
- Sits directly upstream of the PWM controller's button inputs. Its outputs replace raw PUSH0..PUSH3 at that controller.

---
 rtl/push_button_conditioner.sv | 139 +++++++++++++
 1 files changed

// File: rtl/push_button_conditioner.sv
// Push-button front end: per-channel two-flop synchroniser, debouncer, edge pulses
// and a hold FSM that produces long-press and auto-repeat events.
module push_button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] PUSH,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG,
    output logic [N_BTN-1:0] BTN_REPEAT
);

    localparam int HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int DB_W     = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic              sync_1;
        logic              sync_2;
        logic [DB_W-1:0]   db_cnt;
        logic              stable;
        logic              press_q;
        logic              release_q;
        logic [1:0]        state;
        logic [HOLD_W-1:0] hold_cnt;
        logic              long_q;
        logic              repeat_q;

        logic synced;
        logic differ;
        logic flip;
        logic press_edge;
        logic release_edge;

        assign synced       = ~sync_2;
        assign differ       = synced ^ stable;
        assign flip         = differ && (db_cnt == DB_LAST);
        assign press_edge   = flip && !stable;
        assign release_edge = flip && stable;

        // NOTE: synchroniser resets to 1 (released) so a held pin after reset is seen as a fresh press.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync_1 <= 1'b1;
                sync_2 <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments model the flop chain; blocking would collapse it to one stage.
                sync_1 <= PUSH[i];
                sync_2 <= sync_1;
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                db_cnt    <= '0;
                stable    <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if (!differ || flip) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (flip) begin
                    stable <= ~stable;
                end
                press_q   <= press_edge;
                release_q <= release_edge;
            end
        end

        // Release is evaluated first so it suppresses a coincident long/repeat pulse.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state    <= IDLE;
                hold_cnt <= '0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
                if (release_edge) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end else if (press_edge) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end else begin
                    case (state)
                        HOLD: begin
                            if (hold_cnt == HOLD_LAST) begin
                                long_q   <= 1'b1;
                                repeat_q <= 1'b1;
                                state    <= REPEAT;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        REPEAT: begin
                            if (hold_cnt == REPEAT_LAST) begin
                                repeat_q <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign BTN_LEVEL[i]   = stable;
        assign BTN_PRESS[i]   = press_q;
        assign BTN_RELEASE[i] = release_q;
        assign BTN_LONG[i]    = long_q;
        assign BTN_REPEAT[i]  = repeat_q;
    end

endmodule
